alu_result_buffer: RTL and testbench
====================================

# alu_result_buffer

Downstream stage of the 32-bit ALU test path. It captures each ALU result together with its carry-out and zero flag into a small FIFO. It presents the entries to a consumer (monitor, write-back or display logic) through a valid/ready handshake. It also keeps a saturating count of zero-flag results and a sticky overflow indicator, so the ALU can run at full clock rate while a slower consumer drains results.

## Interface

Parameters:
- N, 32, data width of the ALU result
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2
- CW, 16, width of the zero-flag event counter

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge
- async_reset_i  in  1  asynchronous, active-low reset; clears all state immediately
- clear_i  in  1  synchronous flush of the FIFO, the counter and the sticky flag
- valid_i  in  1  ALU result on resultado_i/c_i/zeroflag_i is valid this cycle
- resultado_i  in  N  ALU result
- c_i  in  1  ALU carry-out
- zeroflag_i  in  1  ALU zero flag
- ready_o  out  1  buffer can accept an entry this cycle
- valid_o  out  1  head entry is valid
- ready_i  in  1  consumer accepts the head entry this cycle
- resultado_o  out  N  head entry result
- c_o  out  1  head entry carry
- zeroflag_o  out  1  head entry zero flag
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- zero_cnt_o  out  CW  number of accepted entries with zeroflag_i=1, saturating
- drop_o  out  1  sticky: at least one valid_i arrived while the buffer was full

## Operation

- Push: when valid_i && ready_o, write {resultado_i, c_i, zeroflag_i} at wr_ptr and advance wr_ptr modulo DEPTH.
- Pop: when valid_o && ready_i, advance rd_ptr modulo DEPTH.
- Occupancy states are derived from count:
  - EMPTY (count=0): valid_o=0, ready_o=1.
  - PARTIAL (0<count<DEPTH): valid_o=1, ready_o=1.
  - FULL (count=DEPTH): valid_o=1, ready_o=0.
- Transitions, evaluated on accepted handshakes only:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- ready_o depends only on the registered count; there is no combinational path from ready_i.
  - Push while FULL is refused even if a pop happens in the same cycle.
  - That refused push sets drop_o.
- No bypass. When EMPTY, valid_o=0 regardless of valid_i, and a pushed entry appears at the outputs one cycle later.
- zero_cnt_o increments by 1 on each accepted push with zeroflag_i=1 and holds at 2^CW-1.
- drop_o is set on valid_i && !ready_o and stays at 1 until clear_i or reset.
- clear_i has priority over push and pop in the same cycle.
  - It sets count=0, both pointers=0, zero_cnt_o=0 and drop_o=0.
  - The entry presented with clear_i is discarded.
- Output data (resultado_o, c_o, zeroflag_o) is the array content at rd_ptr. It is don't-care while valid_o=0; the bench must not check it then.

## Timing

- Reset (async_reset_i=0): count_o=0, valid_o=0, ready_o=1, zero_cnt_o=0, drop_o=0, pointers=0, resultado_o/c_o/zeroflag_o=0. Storage contents are not reset.
- Reset asserted mid-operation discards all entries at once. The first push after release is accepted on the first rising edge with async_reset_i=1.
- Latency from push to valid_o=1 at the head: 1 cycle.
- Throughput: 1 entry/cycle with continuous push and pop when 0<count<DEPTH.
- Pointer wrap: from DEPTH-1 to 0, with no bubble.
- count_o, zero_cnt_o and drop_o are registered; each reflects the edge at which its update occurred.

## Structure

- Shared package alu_pkg holds:
  - the default width constant N=32;
  - typedef alu_entry_t = {resultado, c, zeroflag}, width N+2;
  - the default DEPTH and CW constants.
- One sub-module, alu_fifo_mem: a DEPTH x (N+2) register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata), with no reset on the storage.
- Pointers, count, counter, drop flag and handshake logic stay in alu_result_buffer.

## Test plan

- Reset then fill:
  - async_reset_i low: count_o=0, ready_o=1, valid_o=0.
  - After release, push 0x00000005, 0x00000000 (zeroflag=1), 0xFFFFFFFF (c=1), 0x12345678 with ready_i=0.
  - Expect count_o=4, ready_o=0, zero_cnt_o=1.
- Drain in order: from the previous state set ready_i=1 for 4 cycles. Expect the outputs to appear in push order with matching c/zeroflag, then valid_o=0 and count_o=0.
- Overflow:
  - With FULL and ready_i=0, assert valid_i=1 with 0xDEADBEEF. Expect drop_o=1, count_o=4, and 0xDEADBEEF never read out.
  - In the next cycle, push and pop together while FULL. Expect the push refused and count_o=3.
- Streaming wrap-around: push and pop every cycle for 10 entries, 0x1 to 0xA. Expect count_o stable at 1 after the first cycle, outputs 0x1..0xA in order with one-cycle latency, and no drop.
- Saturation and clear:
  - With CW=2, push 5 entries with zeroflag=1 and pop continuously. Expect zero_cnt_o=3.
  - Assert clear_i together with valid_i. Expect count_o=0, zero_cnt_o=0, drop_o=0, and the entry discarded.
- Reset mid-operation: with count_o=2, pulse async_reset_i low between clock edges. Expect valid_o=0 and count_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Shared widths and the entry layout for the ALU result path.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam int ALU_N     = 32;
    localparam int ALU_DEPTH = 4;
    localparam int ALU_CW    = 16;

    typedef struct packed {
        logic [ALU_N-1:0] resultado;
        logic             c;
        logic             zeroflag;
    } alu_entry_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_fifo_mem                                                         |
// | DEPTH x W register array, one write port, asynchronous read port.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 34,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Storage is intentionally left unreset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : alu_fifo_mem
`default_nettype wire

// File: rtl/alu_result_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_result_buffer                                                    |
// | Valid/ready FIFO for ALU results with zero-flag counter and drop flag|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int DEPTH = ALU_DEPTH,
    parameter int CW    = ALU_CW
) (
    input  logic                     clk_i,
    input  logic                     async_reset_i,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  logic [N-1:0]             resultado_i,
    input  logic                     c_i,
    input  logic                     zeroflag_i,
    output logic                     ready_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [N-1:0]             resultado_o,
    output logic                     c_o,
    output logic                     zeroflag_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CW-1:0]            zero_cnt_o,
    output logic                     drop_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] C_ZMAX = {CW{1'b1}};

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("alu_result_buffer: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [CW-1:0] r_zero_cnt;
    logic          r_drop;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [N+1:0]  w_wdata;
    logic [N+1:0]  w_rdata;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // Flow control comes only from the registered count, never from ready_i.
    assign ready_o = !w_full;
    assign valid_o = !w_empty;
    assign w_push  = valid_i && ready_o && !clear_i;
    assign w_pop   = valid_o && ready_i && !clear_i;
    assign w_wdata = {resultado_i, c_i, zeroflag_i};

    alu_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (N + 2),
        .AW    (AW)
    ) u_mem (
        .clk   (clk_i),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk_i or negedge async_reset_i) begin
        if (!async_reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_zero_cnt <= '0;
            r_drop     <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_zero_cnt <= '0;
            r_drop     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && zeroflag_i && (r_zero_cnt != C_ZMAX)) begin
                r_zero_cnt <= r_zero_cnt + 1'b1;
            end
            if (valid_i && !ready_o) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Head data is forced to zero while empty so reset presents clean outputs.
    assign resultado_o = valid_o ? w_rdata[N+1:2] : '0;
    assign c_o         = valid_o ? w_rdata[1]     : 1'b0;
    assign zeroflag_o  = valid_o ? w_rdata[0]     : 1'b0;

    assign count_o     = r_count;
    assign zero_cnt_o  = r_zero_cnt;
    assign drop_o      = r_drop;

endmodule : alu_result_buffer
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_result_buffer                                                 |
// | Scoreboard bench: directed pushes queue expectations, monitor pops.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_result_buffer;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_i;
    logic          valid_i;
    logic [N-1:0]  resultado_i;
    logic          c_i;
    logic          zeroflag_i;
    logic          ready_o;
    logic          valid_o;
    logic          ready_i;
    logic [N-1:0]  resultado_o;
    logic          c_o;
    logic          zeroflag_o;
    logic [2:0]    count_o;
    logic [CW-1:0] zero_cnt_o;
    logic          drop_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [N+1:0] sb[$];

    alu_result_buffer #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk_i         (clk),
        .async_reset_i (rst_n),
        .clear_i       (clear_i),
        .valid_i       (valid_i),
        .resultado_i   (resultado_i),
        .c_i           (c_i),
        .zeroflag_i    (zeroflag_i),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .resultado_o   (resultado_o),
        .c_o           (c_o),
        .zeroflag_o    (zeroflag_o),
        .count_o       (count_o),
        .zero_cnt_o    (zero_cnt_o),
        .drop_o        (drop_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i && !clear_i) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got 0x%0h with empty scoreboard",
                         {resultado_o, c_o, zeroflag_o});
            end else begin
                check("head_entry", 64'({resultado_o, c_o, zeroflag_o}), 64'(sb.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] d, input logic c, input logic z,
                         input logic rdy, input logic accept);
        valid_i     = 1'b1;
        resultado_i = d;
        c_i         = c;
        zeroflag_i  = z;
        ready_i     = rdy;
        if (accept) sb.push_back({d, c, z});
        cyc();
    endtask

    task automatic idle(input logic rdy, input int n);
        valid_i = 1'b0;
        ready_i = rdy;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst_n = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        resultado_i = '0; c_i = 1'b0; zeroflag_i = 1'b0;
        #3;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_zero_cnt", 64'(zero_cnt_o), 64'd0);
        check("rst_drop", 64'(drop_o), 64'd0);
        check("rst_resultado", 64'(resultado_o), 64'd0);
        #9;
        rst_n = 1'b1;

        // Fill with the consumer stalled
        drive(32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b1);
        check("latency_valid", 64'(valid_o), 64'd1);
        drive(32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
        valid_i = 1'b0;
        check("fill_count", 64'(count_o), 64'd4);
        check("fill_ready", 64'(ready_o), 64'd0);
        check("fill_zero_cnt", 64'(zero_cnt_o), 64'd1);

        // Drain in order
        idle(1'b1, 4);
        check("drain_valid", 64'(valid_o), 64'd0);
        check("drain_count", 64'(count_o), 64'd0);

        // Refill, then overflow
        drive(32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(32'h0000_0022, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(32'h0000_0044, 1'b1, 1'b0, 1'b0, 1'b1);
        check("drop_before", 64'(drop_o), 64'd0);
        drive(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_drop", 64'(drop_o), 64'd1);
        check("ovf_count", 64'(count_o), 64'd4);
        drive(32'h0BAD_0BAD, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_pushpop_count", 64'(count_o), 64'd3);
        idle(1'b1, 3);
        check("ovf_drain_count", 64'(count_o), 64'd0);
        check("drop_sticky", 64'(drop_o), 64'd1);

        // Flush flags before streaming
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        check("clear_drop", 64'(drop_o), 64'd0);

        // Streaming with pointer wrap
        for (int i = 1; i <= 10; i++) begin
            drive(32'(i), 1'b0, 1'b0, 1'b1, 1'b1);
            check("stream_count", 64'(count_o), 64'd1);
        end
        idle(1'b1, 1);
        check("stream_end_count", 64'(count_o), 64'd0);
        check("stream_drop", 64'(drop_o), 64'd0);

        // Zero-counter saturation (CW=2)
        for (int i = 0; i < 5; i++) begin
            drive(32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        check("zero_cnt_sat", 64'(zero_cnt_o), 64'd3);
        check("sat_count", 64'(count_o), 64'd1);

        // Clear wins over a simultaneous push and pop
        clear_i = 1'b1;
        drive(32'h0000_0077, 1'b0, 1'b1, 1'b1, 1'b0);
        sb.delete();
        clear_i = 1'b0;
        valid_i = 1'b0;
        check("clr_count", 64'(count_o), 64'd0);
        check("clr_zero_cnt", 64'(zero_cnt_o), 64'd0);
        check("clr_drop", 64'(drop_o), 64'd0);
        check("clr_valid", 64'(valid_o), 64'd0);

        // Asynchronous reset mid-operation
        drive(32'h0000_00A1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(32'h0000_00A2, 1'b0, 1'b0, 1'b0, 1'b1);
        valid_i = 1'b0;
        check("pre_rst_count", 64'(count_o), 64'd2);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst_valid", 64'(valid_o), 64'd0);
        check("async_rst_count", 64'(count_o), 64'd0);
        #1;
        rst_n = 1'b1;
        drive(32'h0000_00AB, 1'b1, 1'b0, 1'b0, 1'b1);
        valid_i = 1'b0;
        check("post_rst_count", 64'(count_o), 64'd1);
        idle(1'b1, 1);
        check("post_rst_drain", 64'(count_o), 64'd0);
        idle(1'b0, 2);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_result_buffer
`default_nettype wire
